axi_write_buffer: RTL and testbench
===================================

AXI_WRITE_BUFFER -- requirements
Module: axi_write_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL provide parameter AXI_ID, default 4'd1, ID driven on awid/wid.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wen  input  1  CPU store request valid.
REQ-006 SHALL have port wstrb_i  input  4  byte enables of store.
REQ-007 SHALL have port waddr_i  input  32  physical store address.
REQ-008 SHALL have port wdata_i  input  32  store data.
REQ-009 SHALL have port w_ok  output  1  store accepted this cycle.
REQ-010 SHALL have port raddr_i  input  32  physical address of pending load, for hazard check.
REQ-011 SHALL have port conflict  output  1  load word-address matches a buffered store.
REQ-012 SHALL have port empty  output  1  no stores buffered or in flight.
REQ-013 SHALL have AXI AW outputs awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1, and input awready 1.
REQ-014 SHALL have AXI W outputs wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1, and input wready 1.
REQ-015 SHALL have AXI B inputs bid 4, bresp 2, bvalid 1, and output bready 1.

Function
REQ-016 SHALL hold a circular FIFO of DEPTH entries {addr, data, strb} with head/tail pointers and a count register of width clog2(DEPTH)+1.
REQ-017 SHALL assert w_ok = wen & (count != DEPTH), combinationally; push on w_ok.
REQ-018 SHALL not accept a push when full, even if a pop occurs the same cycle; requester holds wen.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL wrap pointers modulo DEPTH.
REQ-021 SHALL drive constants: awid = wid = AXI_ID, awlen=0, awsize=3'b010, awburst=2'b01, awlock=0, awcache=0, awprot=0, wlast=1.
REQ-022 SHALL drive awaddr, wdata, wstrb from head entry; these SHALL be stable while awvalid or wvalid is high.
REQ-023 SHALL implement FSM states IDLE, SEND, RESP.
REQ-024 IDLE: awvalid=wvalid=bready=0; go SEND when count!=0.
REQ-025 SEND: awvalid = ~aw_done, wvalid = ~w_done; aw_done set on awvalid&awready, w_done set on wvalid&wready, independently, either order or same cycle.
REQ-026 SEND -> RESP in the cycle after both handshakes complete; aw_done/w_done cleared on entering RESP.
REQ-027 RESP: bready=1; on bvalid pop head; next state SEND if count after pop != 0, else IDLE.
REQ-028 SHALL ignore bid and bresp values; any bvalid in RESP completes the write.
REQ-029 SHALL assert conflict when any valid entry, including the in-flight head, has addr[31:2] == raddr_i[31:2]; combinational, independent of wstrb.
REQ-030 SHALL assert empty = (count == 0).
REQ-031 SHALL deliver a store pushed into an empty buffer in IDLE onto awvalid/wvalid no earlier than the second cycle after push (one cycle IDLE->SEND).
REQ-032 SHALL issue writes strictly in push order, one outstanding AXI transaction at a time.

Reset
REQ-033 SHALL, on rst high at a clock edge, set count=0, pointers=0, state=IDLE, aw_done=w_done=0; outputs awvalid=wvalid=bready=0, w_ok=0 (until rst low), empty=1, conflict=0.
REQ-034 SHALL discard buffered and in-flight stores on reset mid-transaction; no completion is awaited.

Verification
REQ-035 Single store 0x1000_0004/0xDEADBEEF/strb 4'hF into empty buffer, awready=wready=1, bvalid one cycle later -> one AW/W beat with those values, awlen=0, wlast=1, empty=1 after bvalid.
REQ-036 Five back-to-back stores with awready=0 -> w_ok high for first 4, low on 5th; count=4; after one B completes, 5th accepted next cycle.
REQ-037 wready asserted 3 cycles before awready -> wvalid drops after W handshake, awvalid held until AW handshake, exactly one transaction, then RESP.
REQ-038 Buffered store to 0x2000_0008, raddr_i=0x2000_000B -> conflict=1; raddr_i=0x2000_000C -> conflict=0.
REQ-039 Push during RESP with bvalid when count=2 -> count stays 2, next SEND issues oldest remaining entry, pointer wrap exercised over 2*DEPTH stores with in-order data.
REQ-040 rst asserted while in SEND with 3 entries -> next cycle awvalid=wvalid=0, empty=1, state IDLE.

Source files
------------

// File: rtl/axi_write_buffer.sv
// axi_write_buffer: circular store buffer that drains one single-beat AXI write at a time, in push order
module axi_write_buffer #(
    parameter int DEPTH = 4,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    output logic        w_ok,
    input  logic [31:0] raddr_i,
    output logic        conflict,
    output logic        empty,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] head_q, tail_q, off;
    logic [CW-1:0] count_q, count_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d, aw_fin, w_fin, pop, unused_b;
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  strb_q [DEPTH];

    assign w_ok = wen & (count_q != CW'(DEPTH)) & ~rst;
    assign empty = count_q == '0;
    assign count_d = count_q + CW'(w_ok) - CW'(pop);
    assign aw_fin = aw_done_q | awready;
    assign w_fin = w_done_q | wready;
    assign awid = AXI_ID;
    assign wid = AXI_ID;
    assign awlen = 8'd0;
    assign awsize = 3'b010;
    assign awburst = 2'b01;
    assign awlock = 2'b00;
    assign awcache = 4'd0;
    assign awprot = 3'd0;
    assign wlast = 1'b1;
    assign awaddr = addr_q[head_q];
    assign wdata = data_q[head_q];
    assign wstrb = strb_q[head_q];
    assign unused_b = ^{bid, bresp, raddr_i[1:0]};

    // an entry is live when its distance from head is below count, so the in-flight head is included
    always_comb begin
        conflict = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head_q;
            conflict = conflict | (({1'b0, off} < count_q) && (addr_q[i][31:2] == raddr_i[31:2]));
        end
    end

    always_comb begin
        state_d = state_q;
        aw_done_d = aw_done_q;
        w_done_d = w_done_q;
        awvalid = 1'b0;
        wvalid = 1'b0;
        bready = 1'b0;
        pop = 1'b0;
        case (state_q)
            IDLE: state_d = empty ? IDLE : SEND;
            SEND: begin
                awvalid = ~aw_done_q;
                wvalid = ~w_done_q;
                state_d = (aw_fin & w_fin) ? RESP : SEND;
                aw_done_d = aw_fin & ~w_fin;
                w_done_d = w_fin & ~aw_fin;
            end
            RESP: begin
                bready = 1'b1;
                pop = bvalid;
                state_d = ~bvalid ? RESP : (count_d != '0) ? SEND : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q <= head_q + AW'(pop);
            tail_q <= tail_q + AW'(w_ok);
            count_q <= count_d;
            aw_done_q <= aw_done_d;
            w_done_q <= w_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ok) begin
            addr_q[tail_q] <= waddr_i;
            data_q[tail_q] <= wdata_i;
            strb_q[tail_q] <= wstrb_i;
        end
    end
endmodule

// File: tb/tb_axi_write_buffer.sv
// tb_axi_write_buffer: directed checks of buffering, AXI handshakes, hazard detection and reset
module tb_axi_write_buffer;
    logic clk = 1'b0, rst = 1'b1, wen = 1'b0;
    logic [3:0] wstrb_i = '0;
    logic [31:0] waddr_i = '0, wdata_i = '0, raddr_i = '0;
    logic w_ok, conflict, empty, awvalid, wvalid, wlast, bready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, auto_b = 1'b0;
    logic [3:0] awid, wid, awcache, wstrb;
    logic [3:0] bid = 4'h7;
    logic [1:0] bresp = 2'b10;
    logic [31:0] awaddr, wdata;
    logic [7:0] awlen;
    logic [2:0] awsize, awprot;
    logic [1:0] awburst, awlock;
    logic [31:0] aw_q [$];
    logic [35:0] w_q [$];
    int n_cmp = 0, n_bad = 0;

    axi_write_buffer #(.DEPTH(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wstrb_i(wstrb_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .w_ok(w_ok), .raddr_i(raddr_i), .conflict(conflict), .empty(empty),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // handshakes are recorded mid-cycle, while valid/ready are stable
    always @(negedge clk) begin
        if (awvalid && awready) aw_q.push_back(awaddr);
        if (wvalid && wready) w_q.push_back({wdata, wstrb});
        bvalid = auto_b & bready & ~bvalid & ~rst;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i = 0;
        wen = 1'b1; waddr_i = a; wdata_i = d; wstrb_i = s;
        #1;
        while (!w_ok && i < 50) begin tick(); i++; end
        if (!w_ok) chk("push_timeout", w_ok, 1);
        tick();
        wen = 1'b0;
    endtask

    task automatic wait_empty(input string tag, input int n);
        for (int i = 0; i < n && !empty; i++) tick();
        chk(tag, empty, 1);
    endtask

    initial begin
        int ab, wb;
        logic [4:0] ok_bits;
        // reset: a store request must not be accepted while rst is high
        wen = 1'b1;
        tick(); tick();
        chk("rst_wok", w_ok, 0);
        chk("rst_empty", empty, 1);
        chk("rst_valids", {awvalid, wvalid, bready, conflict}, 0);
        wen = 1'b0; rst = 1'b0;
        tick();
        chk("consts", {awid, wid, awlen, awsize, awburst, awlock, awcache, awprot, wlast},
            {4'd1, 4'd1, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});

        // single store, both channels ready
        awready = 1'b1; wready = 1'b1; auto_b = 1'b1;
        ab = aw_q.size(); wb = w_q.size();
        push(32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
        chk("lat_idle", {awvalid, wvalid, empty}, 3'b000);
        tick();
        chk("lat_send", {awvalid, wvalid}, 2'b11);
        wait_empty("single_empty", 20);
        chk("single_aw_n", aw_q.size() - ab, 1);
        chk("single_w_n", w_q.size() - wb, 1);
        chk("single_awaddr", aw_q[ab], 32'h1000_0004);
        chk("single_wdata", w_q[wb], {32'hDEAD_BEEF, 4'hF});

        // five back-to-back stores while AW is stalled
        awready = 1'b0; wready = 1'b1; auto_b = 1'b0;
        ab = aw_q.size();
        for (int k = 0; k < 5; k++) begin
            wen = 1'b1; waddr_i = 32'h3000_0000 + 32'(4 * k); wdata_i = 32'h100 + 32'(k); wstrb_i = 4'hF;
            #1;
            ok_bits[k] = w_ok;
            tick();
        end
        chk("full_wok_pattern", ok_bits, 5'b01111);
        chk("full_count", dut.count_q, 4);
        awready = 1'b1; auto_b = 1'b1;
        for (int i = 0; i < 20 && !w_ok; i++) tick();
        chk("full_fifth_ok", w_ok, 1);
        chk("full_count_after_b", dut.count_q, 3);
        tick();
        wen = 1'b0;
        wait_empty("full_empty", 80);
        for (int k = 0; k < 5; k++) chk("full_order", aw_q[ab + k], 32'h3000_0000 + 32'(4 * k));

        // W accepted three cycles before AW
        awready = 1'b0; wready = 1'b0;
        ab = aw_q.size(); wb = w_q.size();
        push(32'h4000_0010, 32'h5555_AAAA, 4'h3);
        tick();
        wready = 1'b1;
        tick();
        chk("w_first_valids", {awvalid, wvalid}, 2'b10);
        tick(); tick();
        chk("w_first_hold", {awvalid, wvalid, bready}, 3'b100);
        awready = 1'b1;
        tick();
        chk("w_first_resp", {awvalid, wvalid, bready}, 3'b001);
        wait_empty("w_first_empty", 20);
        chk("w_first_aw_n", aw_q.size() - ab, 1);
        chk("w_first_w", {32'(w_q.size() - wb), w_q[wb]}, {32'd1, 32'h5555_AAAA, 4'h3});

        // load hazard against a buffered store
        awready = 1'b0; wready = 1'b0;
        push(32'h2000_0008, 32'h1234_5678, 4'h1);
        raddr_i = 32'h2000_000B; #1;
        chk("conflict_same_word", conflict, 1);
        raddr_i = 32'h2000_000C; #1;
        chk("conflict_next_word", conflict, 0);
        tick();
        raddr_i = 32'h2000_0008; #1;
        chk("conflict_in_flight", {awvalid, conflict}, 2'b11);
        awready = 1'b1; wready = 1'b1;
        wait_empty("conflict_drain", 20);
        chk("conflict_after_drain", conflict, 0);

        // push in the same cycle as a B completion with two entries buffered
        awready = 1'b0; wready = 1'b0;
        ab = aw_q.size();
        push(32'h6000_0000, 32'hA, 4'hF);
        push(32'h6000_0004, 32'hB, 4'hF);
        awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 20 && !bready; i++) tick();
        chk("pp_in_resp", bready, 1);
        wen = 1'b1; waddr_i = 32'h6000_0008; wdata_i = 32'hC; wstrb_i = 4'hF;
        #1;
        chk("pp_wok", w_ok, 1);
        tick();
        wen = 1'b0;
        chk("pp_count", dut.count_q, 2);
        chk("pp_next_head", {awvalid, awaddr}, {1'b1, 32'h6000_0004});
        wait_empty("pp_empty", 40);
        for (int k = 0; k < 3; k++) chk("pp_order", aw_q[ab + k], 32'h6000_0000 + 32'(4 * k));

        // 2*DEPTH stores to walk the pointers around the ring
        wb = w_q.size();
        for (int k = 0; k < 8; k++) push(32'h5000_0000 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 4'hF);
        wait_empty("wrap_empty", 100);
        for (int k = 0; k < 8; k++) chk("wrap_data", w_q[wb + k][35:4], 32'hC0DE_0000 + 32'(k));

        // reset in the middle of a transaction with three stores buffered
        awready = 1'b0; wready = 1'b0; auto_b = 1'b0;
        for (int k = 0; k < 3; k++) push(32'h7000_0000 + 32'(4 * k), 32'(k), 4'hF);
        chk("rst_mid_send", awvalid, 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_outputs", {awvalid, wvalid, bready, empty}, 4'b0001);
        chk("rst_mid_state", dut.state_q, 0);
        rst = 1'b0; awready = 1'b1; wready = 1'b1;
        tick(); tick();
        chk("rst_mid_quiet", {awvalid, wvalid, empty}, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
